// File: rtl/mp_add_arbiter.sv
// Purpose : two-requester round-robin sequencer sharing one 8-bit ripple adder slice for NBYTES-wide add/sub.
// Latency : accept at edge T, result visible (res_valid=1) in cycle T+NBYTES+1; issue interval NBYTES+2 cycles.
// Backpr. : result held stable in DONE until res_ready; requester readies are 0 outside IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshake (ready combinational from state, valids, pointer)
//   req{0,1}_a/_b/_sub       operands (W = 8*NBYTES bits) and subtract select
//   res_valid/res_ready      result handshake
//   res_data/carry/id        result, final carry out (sub: 1 = no borrow), issuing requester
//   res_ovf                  signed overflow, present only when MPADD_OVF_EN is defined

// Single 8-bit ripple-carry slice.
module bitadder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[8];
endmodule

module mp_add_arbiter #(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_carry,
`ifdef MPADD_OVF_EN
    output logic         res_ovf,
`endif
    output logic         res_id
);
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;      // already inverted for subtract
    logic [W-1:0]    res_q, res_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;
    logic            ptr_q, ptr_d;  // last-served requester
`ifdef MPADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic            gnt0, gnt1;
    logic [7:0]      a_byte, b_byte, sum_byte;
    logic            cout;

    // Round-robin: on a tie the requester not served last wins.
    assign gnt0 = req0_valid & (~req1_valid | ptr_q);
    assign gnt1 = req1_valid & (~req0_valid | ~ptr_q);

    // Readies depend only on state, valids and pointer (never on res_ready);
    // gated by rst so they read 0 while reset is held.
    assign req0_ready = (state_q == IDLE) & ~rst & gnt0;
    assign req1_ready = (state_q == IDLE) & ~rst & gnt1;

    assign a_byte = a_q[{k_q, 3'b000} +: 8];
    assign b_byte = b_q[{k_q, 3'b000} +: 8];

    bitadder_8 u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (sum_byte),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        k_d     = k_q;
        carry_d = carry_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef MPADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    // Two's-complement subtract: A + ~B + 1, the +1 entering as initial carry.
                    if (gnt0) begin
                        a_d     = req0_a;
                        b_d     = req0_sub ? ~req0_b : req0_b;
                        carry_d = req0_sub;
                        id_d    = 1'b0;
                    end else begin
                        a_d     = req1_a;
                        b_d     = req1_sub ? ~req1_b : req1_b;
                        carry_d = req1_sub;
                        id_d    = 1'b1;
                    end
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d[{k_q, 3'b000} +: 8] = sum_byte;
                carry_d                   = cout;
                if (k_q == KW'(NBYTES - 1)) begin
                    k_d     = '0;
                    ptr_d   = id_q;
                    state_d = DONE;
`ifdef MPADD_OVF_EN
                    // Carry into bit 7 recovered from the sum: c7 = s7 ^ a7 ^ b7.
                    ovf_d   = (sum_byte[7] ^ a_byte[7] ^ b_byte[7]) ^ cout;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
`ifdef MPADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
`ifdef MPADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;
`ifdef MPADD_OVF_EN
    assign res_ovf   = ovf_q;
`endif
endmodule

// File: doc/mp_add_arbiter.md
# mp_add_arbiter

Sequencer and arbiter that shares a single 8-bit ripple full-adder slice (bitadder_8) between two requesters. Each request is an NBYTES-wide add or subtract, executed one byte per cycle, least-significant byte first, with the carry registered between bytes. The block sits between two operand sources and a single result sink. Round-robin arbitration guarantees fairness when both requesters are pending.

## Interface
- NBYTES, 4, operand width in bytes (≥1); W = 8*NBYTES
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&ready
- req0_a / req1_a  in  W  operand A (unsigned/two's complement)
- req0_b / req1_b  in  W  operand B
- req0_sub / req1_sub  in  1  1 = A−B, 0 = A+B
- res_valid  out  1  result held stable until taken
- res_ready  in  1  sink accepts result
- res_data  out  W  sum/difference, modulo 2^W
- res_carry  out  1  final carry out (subtract: 1 = no borrow)
- res_id  out  1  index of requester that issued this result

## Operation
- States: IDLE, ADD, DONE.
- IDLE: arbitrate. Only the granted requester sees ready=1; the other sees 0. If only one is valid, that one is granted. If both are valid, grant the one not served last. The last-served pointer resets to 1, so req0 wins the first tie.
- Accept (valid&ready in IDLE): latch A, B (inverted if sub), sub, id. Set byte counter k=0 and carry register = sub. Go to ADD.
- ADD: feed adder A byte k, B byte k, and the carry register. Write the sum byte into result byte k and the adder carry-out into the carry register. Increment k. After byte NBYTES−1, go to DONE. Update the last-served pointer.
- DONE: res_valid=1; res_data, res_carry and res_id are stable. On res_ready=1, go to IDLE. Readies stay 0 during the handoff cycle.
- Requester inputs are ignored outside IDLE. Operand changes after acceptance have no effect.
- A requester that drops valid before being granted is simply not served. No state is retained for it.
- Reset (async, any state, including mid-ADD): state=IDLE, all readies=0, res_valid=0, res_data=0, res_carry=0, res_id=0, k=0, pointer=1. A partial result is discarded.

## Timing
- Readies are combinational from state, valids and pointer. They are high only in IDLE.
- Accept at edge T. Byte k is computed in cycle T+1+k. res_valid rises after edge T+NBYTES, i.e. it is visible in cycle T+NBYTES+1.
- Minimum issue interval: NBYTES+2 cycles (accept, NBYTES ADD cycles, DONE with res_ready=1). The next accept occurs in the following IDLE cycle.
- res_ready held low stalls in DONE indefinitely, with outputs unchanged.
- The adder path is one 8-bit ripple per cycle. No combinational path runs from res_ready to the readies.

## Configuration
- MPADD_OVF_EN defined: adds output res_ovf (1 bit, reset 0, valid with res_valid). It is the two's-complement signed overflow, computed as the carry into the MSB XOR the carry out of the MSB of the final byte.
- Undefined: no res_ovf port and no overflow logic. All other behaviour is identical.

## Test plan
- NBYTES=4, req0 only: A=0x000000FF, B=0x00000001, sub=0 → after the accept edge, res_valid visible 5 cycles later. res_data=0x00000100, res_carry=0, res_id=0.
- Subtract with borrow: req1, A=0x00000000, B=0x00000001, sub=1 → res_data=0xFFFFFFFF, res_carry=0, res_id=1. With MPADD_OVF_EN: A=0x80000000, B=1, sub=1 → res_data=0x7FFFFFFF, res_ovf=1.
- Both valid continuously from reset, res_ready=1 → grants alternate 0,1,0,1. Accepts occur every 6 cycles.
- Carry chain: A=0xFFFFFFFF, B=0x00000001, sub=0 → res_data=0x00000000, res_carry=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid stays 1, outputs are unchanged and both readies stay 0. Releasing res_ready returns the block to IDLE in the next cycle.
- Assert rst during cycle 2 of ADD → all outputs go to 0 immediately and no res_valid appears. A fresh request after deassertion completes correctly.
